// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and default oversample ratio.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_tx_state_e;

endpackage

// File: rtl/uart_tx_fsm.sv
// UART transmitter: 8N1/8N2 framing, LSB first, timed by an external oversample tick.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_fsm
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_en,
  input  logic       baud_tick,
  input  logic       tx_start,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       busy,
  output logic       baud_en,
  output logic       done
);

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  uart_tx_state_e state_q, state_d;
  logic [3:0]     tick_q, tick_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           done_q, done_d;
  logic           bit_end;
`ifdef UART_TX_PARITY_EN
  logic           parity_q, parity_d;
`endif

  assign bit_end = baud_tick && (tick_q == TICK_LAST);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    if (state_q != ST_IDLE && baud_tick) begin
      tick_d = bit_end ? 4'd0 : tick_q + 4'd1;
    end
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (tx_start && tx_en) begin
          state_d = ST_START;
          shift_d = data_in;
          tick_d  = 4'd0;
          bit_d   = 3'd0;
          tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^data_in;
`endif
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            // bit counter is reused to count stop bits
            bit_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = parity_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            state_d = ST_IDLE;
            bit_d   = 3'd0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tick_d  = 4'd0;
        bit_d   = 3'd0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= ST_IDLE;
      tick_q   <= 4'd0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign busy    = (state_q != ST_IDLE);
  assign baud_en = busy;
  assign done    = done_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Scoreboard bench for uart_tx_fsm: a 1-stop DUT ticked every clk and a 2-stop DUT ticked every 3rd clk.
module tb_uart_tx_fsm;

  localparam int OVS = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam logic [11:0] F_A5  = 12'b0_1_0_10100101_0;
  localparam logic [11:0] F_01  = 12'b0_1_1_00000001_0;
  localparam logic [11:0] F_3C  = 12'b0_1_0_00111100_0;
  localparam logic [11:0] F_C3  = 12'b0_1_0_11000011_0;
  localparam logic [11:0] F_55  = 12'b0_1_0_01010101_0;
  localparam logic [11:0] F_55B = 12'b1_1_0_01010101_0;
`else
  localparam int NB = 10;
  localparam logic [11:0] F_A5  = 12'b00_1_10100101_0;
  localparam logic [11:0] F_01  = 12'b00_1_00000001_0;
  localparam logic [11:0] F_3C  = 12'b00_1_00111100_0;
  localparam logic [11:0] F_C3  = 12'b00_1_11000011_0;
  localparam logic [11:0] F_55  = 12'b00_1_01010101_0;
  localparam logic [11:0] F_55B = 12'b0_1_1_01010101_0;
`endif

  typedef struct {
    logic [11:0] bits;
    int          nbits;
    int          cpt;
    int          extra;
    int          stop_clks;
    bit          contig;
    bit          abort;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic trace [0:1023];

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_en_a, tick_en_a, tx_start_a;
  logic [7:0] data_a;
  logic       tx_a, busy_a, baud_en_a, done_a;
  logic       tx_start_b, tick_b;
  logic [7:0] data_b;
  logic [1:0] tick_cnt_b;
  logic       tx_b, busy_b, baud_en_b, done_b;
  logic       sel;
  logic       mon_tx, mon_busy, mon_be, mon_done;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fsm dut_a (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en_a), .baud_tick(tick_en_a),
    .tx_start(tx_start_a), .data_in(data_a),
    .tx(tx_a), .busy(busy_a), .baud_en(baud_en_a), .done(done_a)
  );

  uart_tx_fsm #(.OVERSAMPLE(16), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_en(1'b1), .baud_tick(tick_b),
    .tx_start(tx_start_b), .data_in(data_b),
    .tx(tx_b), .busy(busy_b), .baud_en(baud_en_b), .done(done_b)
  );

  // Baud generator model for dut_b: one tick every 3 clks while enabled
  always @(posedge clk) begin
    if (baud_en_b !== 1'b1) tick_cnt_b <= 2'd0;
    else tick_cnt_b <= (tick_cnt_b == 2'd2) ? 2'd0 : tick_cnt_b + 2'd1;
  end
  assign tick_b = (baud_en_b === 1'b1) && (tick_cnt_b == 2'd2);

  assign mon_tx   = sel ? tx_b      : tx_a;
  assign mon_busy = sel ? busy_b    : busy_a;
  assign mon_be   = sel ? baud_en_b : baud_en_a;
  assign mon_done = sel ? done_b    : done_a;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [11:0] bits, input int nbits, input int cpt,
                      input int extra, input int stop_clks, input bit contig, input bit abort);
    exp_t e;
    e = '{bits: bits, nbits: nbits, cpt: cpt, extra: extra,
          stop_clks: stop_clks, contig: contig, abort: abort};
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (mon_done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 32'(n < limit), 32'd1);
  endtask

  task automatic send_a(input logic [7:0] d);
    @(negedge clk);
    data_a = d;
    tx_start_a = 1'b1;
    @(negedge clk);
    tx_start_a = 1'b0;
  endtask

  // Monitor: captures each frame from busy rise to busy fall and scores it
  initial begin : monitor
    int          len, start_cyc, last_done_cyc, pos, trail;
    bit          prev_busy, prev_done, be_bad;
    logic [11:0] obs;
    exp_t        e;
    prev_busy = 1'b0;
    prev_done = 1'b0;
    last_done_cyc = -10;
    forever begin
      @(negedge clk);
      if (prev_done) check("done_one_clk", 32'(mon_done), 32'd0);
      prev_done = 1'b0;
      if (mon_busy === 1'b1 && !prev_busy) begin
        start_cyc = cyc;
        len = 0;
        be_bad = 1'b0;
        while (mon_busy === 1'b1 && len < 1024) begin
          trace[len] = mon_tx;
          if (mon_be !== mon_busy) be_bad = 1'b1;
          len++;
          @(negedge clk);
        end
        if (mon_be !== mon_busy) be_bad = 1'b1;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_frame: got frame of %0d clks, expected none", len);
        end else begin
          e = exp_q.pop_front();
          check("baud_en_eq_busy", 32'(be_bad), 32'd0);
          if (e.abort) begin
            check("abort_no_done", 32'(mon_done), 32'd0);
          end else begin
            check("frame_len", 32'(len), 32'(e.nbits * OVS * e.cpt + e.extra));
            obs = '0;
            for (int i = 0; i < e.nbits; i++) begin
              pos = (i * OVS + OVS / 2) * e.cpt;
              if (pos < len) obs[i] = trace[pos];
            end
            check("frame_bits", 32'(obs), 32'(e.bits));
            check("done_pulse", 32'(mon_done), 32'd1);
            check("idle_tx_high", 32'(mon_tx), 32'd1);
            if (e.contig) check("contiguous", 32'(start_cyc), 32'(last_done_cyc + 1));
            if (e.stop_clks > 0) begin
              trail = 0;
              for (int i = len - 1; i >= 0; i--) begin
                if (trace[i] !== 1'b1) break;
                trail++;
              end
              check("stop_len", 32'(trail), 32'(e.stop_clks));
            end
            last_done_cyc = cyc;
            prev_done = 1'b1;
          end
        end
      end
      prev_busy = (mon_busy === 1'b1);
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic saved_tx;
    sel = 1'b0;
    rst_n = 1'b1;
    tx_en_a = 1'b1;
    tick_en_a = 1'b1;
    tx_start_a = 1'b0;
    data_a = 8'h00;
    tx_start_b = 1'b0;
    data_b = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx_a", 32'(tx_a), 32'd1);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_baud_en_a", 32'(baud_en_a), 32'd0);
    check("rst_done_a", 32'(done_a), 32'd0);
    check("rst_tx_b", 32'(tx_b), 32'd1);
    check("rst_busy_b", 32'(busy_b), 32'd0);
    rst_n = 1'b0;

    // 0xA5 basic frame
    push(F_A5, NB, 1, 0, 0, 1'b0, 1'b0);
    send_a(8'hA5);
    check("start_latency_tx", 32'(tx_a), 32'd0);
    check("start_latency_busy", 32'(busy_a), 32'd1);
    wait_done(400);

    // 0x01 with tx_en dropped mid-frame
    push(F_01, NB, 1, 0, 0, 1'b0, 1'b0);
    send_a(8'h01);
    repeat (20) @(negedge clk);
    tx_en_a = 1'b0;
    wait_done(400);
    tx_start_a = 1'b1;
    repeat (3) @(negedge clk);
    tx_start_a = 1'b0;
    check("tx_en_low_ignored", 32'(busy_a), 32'd0);
    tx_en_a = 1'b1;

    // 0x3C then 0xC3 started in the done cycle
    push(F_3C, NB, 1, 0, 0, 1'b0, 1'b0);
    send_a(8'h3C);
    wait_done(400);
    push(F_C3, NB, 1, 0, 0, 1'b1, 1'b0);
    data_a = 8'hC3;
    tx_start_a = 1'b1;
    @(negedge clk);
    tx_start_a = 1'b0;
    wait_done(400);

    // 0x55 with a 0xFF request and data change mid-frame
    push(F_55, NB, 1, 0, 0, 1'b0, 1'b0);
    send_a(8'h55);
    repeat (40) @(negedge clk);
    data_a = 8'hFF;
    tx_start_a = 1'b1;
    @(negedge clk);
    tx_start_a = 1'b0;
    wait_done(400);
    repeat (5) @(negedge clk);
    check("busy_not_queued", 32'(busy_a), 32'd0);

    // 0xA5 with ticks paused for 20 clks inside the stop bit
    push(F_A5, NB, 1, 20, 0, 1'b0, 1'b0);
    send_a(8'hA5);
    repeat ((NB - 1) * OVS + 8) @(negedge clk);
    tick_en_a = 1'b0;
    saved_tx = tx_a;
    repeat (20) @(negedge clk);
    check("hold_tx", 32'(tx_a), 32'(saved_tx));
    check("hold_busy", 32'(busy_a), 32'd1);
    tick_en_a = 1'b1;
    wait_done(400);

    // reset in data bit 4, then a clean 0x55 frame
    push(F_A5, NB, 1, 0, 0, 1'b0, 1'b1);
    send_a(8'hA5);
    repeat (88) @(negedge clk);
    check("data_bit4_level", 32'(tx_a), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_tx", 32'(tx_a), 32'd1);
    check("midrst_busy", 32'(busy_a), 32'd0);
    check("midrst_baud_en", 32'(baud_en_a), 32'd0);
    check("midrst_done", 32'(done_a), 32'd0);
    rst_n = 1'b0;
    push(F_55, NB, 1, 0, 0, 1'b0, 1'b0);
    send_a(8'h55);
    wait_done(400);

    // reset wins over a simultaneous tx_start
    @(negedge clk);
    rst_n = 1'b1;
    tx_start_a = 1'b1;
    data_a = 8'h81;
    @(negedge clk);
    rst_n = 1'b0;
    tx_start_a = 1'b0;
    check("rst_priority_busy", 32'(busy_a), 32'd0);
    check("rst_priority_tx", 32'(tx_a), 32'd1);

    // two stop bits, tick every 3rd clk
    repeat (3) @(negedge clk);
    sel = 1'b1;
    push(F_55B, NB + 1, 3, 0, 96, 1'b0, 1'b0);
    @(negedge clk);
    data_b = 8'h55;
    tx_start_b = 1'b1;
    @(negedge clk);
    tx_start_b = 1'b0;
    wait_done(900);

    repeat (10) @(negedge clk);
    check("all_frames_seen", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fsm.md
UART_TX_FSM -- requirements
Module: uart_tx_fsm

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, giving baud_tick pulses per bit period (legal values 8 or 16).
REQ-002 SHALL have parameter STOP_BITS, default 1, giving the number of stop bits (legal values 1 or 2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-high (asserted = 1).
REQ-005 SHALL have port tx_en, input, 1 bit: transmitter enable, sampled only in IDLE.
REQ-006 SHALL have port baud_tick, input, 1 bit: oversample tick from the baud generator, one clk wide.
REQ-007 SHALL have port tx_start, input, 1 bit: request to send data_in.
REQ-008 SHALL have port data_in, input, 8 bits: byte to send, sampled only on acceptance.
REQ-009 SHALL have port tx, output, 1 bit: registered serial line, idle-high.
REQ-010 SHALL have port busy, output, 1 bit: frame in progress.
REQ-011 SHALL have port baud_en, output, 1 bit: baud generator enable, equal to busy.
REQ-012 SHALL have port done, output, 1 bit: one-clk pulse marking frame completion.

Function
REQ-013 SHALL implement states IDLE, START, DATA, (PARITY), STOP; any illegal encoding SHALL return to IDLE.
REQ-014 In IDLE, tx_start=1 with tx_en=1 SHALL accept the request, latch data_in into the shift register, clear the tick and bit counters, and enter START at the next edge.
REQ-015 tx SHALL go low, and busy/baud_en high, on the clk edge that enters START; latency from acceptance to start bit is 1 clk.
REQ-016 Each bit period SHALL last exactly OVERSAMPLE baud_ticks, counted by a 4-bit tick counter that wraps to 0 at OVERSAMPLE-1.
REQ-017 DATA SHALL send 8 bits LSB first, shifting on each bit-period end, with a 3-bit bit counter; after bit 7 the FSM SHALL go to PARITY if compiled in, else to STOP.
REQ-018 STOP SHALL drive tx=1 for STOP_BITS*OVERSAMPLE ticks, then return to IDLE.
REQ-019 done SHALL be registered and high for exactly the first clk in IDLE after STOP; busy and baud_en SHALL be low in that same clk.
REQ-020 A tx_start accepted in the done cycle SHALL start a new frame with no extra idle clk.
REQ-021 tx_start while busy SHALL be ignored and not queued; data_in changes while busy SHALL not affect the frame.
REQ-022 Deasserting tx_en mid-frame SHALL not abort the frame.
REQ-023 Without baud_tick pulses, state and tx SHALL hold.

Reset
REQ-024 rst_n=1 SHALL force IDLE, tx=1, busy=0, baud_en=0, done=0, and clear all counters and the shift register at the next edge, including mid-frame.
REQ-025 rst_n SHALL take priority over tx_start in the same cycle.

Configuration
REQ-026 Macro UART_TX_PARITY_EN defined SHALL insert a PARITY state between DATA and STOP that sends even parity (XOR of the latched byte) for one bit period.
REQ-027 Without UART_TX_PARITY_EN the PARITY state and its logic SHALL be absent, and DATA SHALL go directly to STOP.

Structure
REQ-028 Package uart_pkg SHALL hold the state enumeration type and the OVERSAMPLE default constant shared with the receiver.
REQ-029 No sub-module is natural: shift register, counters and parity reduction SHALL be in-line.

Verification
REQ-030 With baud_tick every clk, 0xA5 sent SHALL give tx = 0,1,0,1,0,0,1,0,1,1, each 16 clks, with done one clk after frame end (160 clks).
REQ-031 With UART_TX_PARITY_EN, 0xA5 SHALL insert parity 0 before stop, and 0x01 SHALL insert parity 1; the frame SHALL be 176 clks.
REQ-032 0x3C then 0xC3, with the second tx_start in the done cycle, SHALL give two contiguous frames with no idle clk.
REQ-033 tx_start pulsed mid-frame with data_in=0xFF SHALL leave the current frame unchanged and start no second frame.
REQ-034 rst_n asserted in DATA bit 4 SHALL give tx=1, busy=0, baud_en=0 next clk, and a following 0x55 frame SHALL be correct.
REQ-035 STOP_BITS=2 with baud_tick every 3rd clk SHALL hold the stop level for 32 ticks (96 clks).
